// File: rtl/fma_align_add.sv
// ---------------------------------------------------------------------------
// fma_align_add
//
// Purpose:
//   Alignment and add/subtract back end of a two-product fused multiply-add.
//   It takes two products (a*b and c*d) and puts the one with the larger
//   exponent in X and the other in Y. It right-shifts Y's significand to X's
//   exponent, then adds or subtracts the magnitudes. The result is left
//   unnormalised, so a later normaliser or rounder can finish the job.
//
// Pipeline (3 stages, one transfer per cycle when unstalled):
//   stage 1 : signed exponent compare, X/Y swap, exponent difference
//   stage 2 : extend significands to 50 bits and right-shift Y by the difference
//   stage 3 : 51-bit magnitude add or subtract; zero-result sign fix-up
//
// Handshake (the same rule on every boundary):
//   A beat moves across a boundary on any rising edge where the producer's
//   valid and the consumer's ready are both high. A stage is ready when it is
//   empty or when its contents leave downstream on the same edge. This lets
//   a full pipeline move one beat per cycle with no bubbles. A stage holds
//   its data unchanged while it cannot drain, so outputs stay stable under
//   backpressure.
//
// Ports:
//   clk, rst_n          clock; synchronous active-low reset
//   in_valid / in_ready input handshake for one product pair
//   ab_sign, cd_sign    product signs
//   ab_exp, cd_exp      10-bit two's-complement unbiased product exponents
//   ab_man, cd_man      48-bit unsigned product significands (2.46)
//   op_sel              1 = magnitude subtract, 0 = magnitude add
//   out_valid/out_ready output handshake
//   res_sign            sign of X (forced to 0 for an exact zero)
//   res_exp             exponent of X
//   res_man             51-bit unnormalised magnitude; bit 50 is the carry
//
// Configuration:
//   FMA_ALIGN_STICKY_EN  when defined, stage 2 ORs every bit shifted out of Y
//                        into bit 0 of the aligned Y (sticky). By default the
//                        shifted-out bits are discarded.
// ---------------------------------------------------------------------------
module fma_align_add (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        ab_sign,
    input  logic        cd_sign,
    input  logic [9:0]  ab_exp,
    input  logic [9:0]  cd_exp,
    input  logic [47:0] ab_man,
    input  logic [47:0] cd_man,
    input  logic        op_sel,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        res_sign,
    output logic [9:0]  res_exp,
    output logic [50:0] res_man
);

    // -----------------------------------------------------------------------
    // Stage registers
    // -----------------------------------------------------------------------
    logic        s1Valid;
    logic        s1XSign;
    logic [9:0]  s1XExp;
    logic [47:0] s1XMan;
    logic [47:0] s1YMan;
    logic [10:0] s1Diff;
    logic        s1Op;

    logic        s2Valid;
    logic        s2XSign;
    logic [9:0]  s2XExp;
    logic [49:0] s2XMan;
    logic [49:0] s2YMan;
    logic        s2Op;

    // -----------------------------------------------------------------------
    // Ready chain: each stage can load when empty or draining this cycle.
    // -----------------------------------------------------------------------
    logic s1Ready;
    logic s2Ready;
    logic s3Ready;

    assign s3Ready  = out_ready;
    assign s2Ready  = ~out_valid | s3Ready;
    assign s1Ready  = ~s2Valid | s2Ready;
    assign in_ready = ~s1Valid | s1Ready;

    // -----------------------------------------------------------------------
    // Stage 1 combinational: pick X (larger exponent, then larger significand,
    // ab on a full tie) so that X - Y is never negative in stage 3.
    // -----------------------------------------------------------------------
    logic        abIsX;
    logic        abExpGreater;
    logic        expEqual;
    logic        xSignC;
    logic [9:0]  xExpC;
    logic [9:0]  yExpC;
    logic [47:0] xManC;
    logic [47:0] yManC;
    logic [10:0] diffC;

    always_comb begin
        abExpGreater = $signed(ab_exp) > $signed(cd_exp);
        expEqual     = (ab_exp == cd_exp);
        abIsX        = abExpGreater | (expEqual & (ab_man >= cd_man));
        xSignC       = abIsX ? ab_sign : cd_sign;
        xExpC        = abIsX ? ab_exp  : cd_exp;
        yExpC        = abIsX ? cd_exp  : ab_exp;
        xManC        = abIsX ? ab_man  : cd_man;
        yManC        = abIsX ? cd_man  : ab_man;
        // Sign-extend to 11 bits; the difference spans 0..1023, never negative.
        diffC        = {xExpC[9], xExpC} - {yExpC[9], yExpC};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1Valid <= 1'b0;
            s1XSign <= 1'b0;
            s1XExp  <= '0;
            s1XMan  <= '0;
            s1YMan  <= '0;
            s1Diff  <= '0;
            s1Op    <= 1'b0;
        end else if (in_ready) begin
            s1Valid <= in_valid;
            if (in_valid) begin
                s1XSign <= xSignC;
                s1XExp  <= xExpC;
                s1XMan  <= xManC;
                s1YMan  <= yManC;
                s1Diff  <= diffC;
                s1Op    <= op_sel;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stage 2 combinational: two guard bits below the 2.46 significand, then
    // the alignment shift. Differences of 50 or more shift Y out entirely.
    // -----------------------------------------------------------------------
    logic [49:0] yExt;
    logic [49:0] yShift;
    logic [49:0] yAligned;
    logic        shiftAll;

`ifdef FMA_ALIGN_STICKY_EN
    logic [49:0] lostMask;
    logic        sticky;
`endif

    always_comb begin
        yExt     = {s1YMan, 2'b00};
        shiftAll = (s1Diff >= 11'd50);
        yShift   = shiftAll ? '0 : (yExt >> s1Diff);
`ifdef FMA_ALIGN_STICKY_EN
        // Mask covers exactly the bit positions that fall off the right end.
        lostMask = shiftAll ? '1 : ~({50{1'b1}} << s1Diff);
        sticky   = |(yExt & lostMask);
        yAligned = {yShift[49:1], yShift[0] | sticky};
`else
        yAligned = yShift;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2Valid <= 1'b0;
            s2XSign <= 1'b0;
            s2XExp  <= '0;
            s2XMan  <= '0;
            s2YMan  <= '0;
            s2Op    <= 1'b0;
        end else if (s1Ready) begin
            s2Valid <= s1Valid;
            if (s1Valid) begin
                s2XSign <= s1XSign;
                s2XExp  <= s1XExp;
                s2XMan  <= {s1XMan, 2'b00};
                s2YMan  <= yAligned;
                s2Op    <= s1Op;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stage 3 combinational: add or subtract magnitudes; an exact zero is
    // reported as +0 whatever the sign of X.
    // -----------------------------------------------------------------------
    logic [50:0] sumC;
    logic        signC;

    always_comb begin
        if (s2Op) begin
            sumC = {1'b0, s2XMan} - {1'b0, s2YMan};
        end else begin
            sumC = {1'b0, s2XMan} + {1'b0, s2YMan};
        end
        signC = (sumC == '0) ? 1'b0 : s2XSign;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            res_sign  <= 1'b0;
            res_exp   <= '0;
            res_man   <= '0;
        end else if (s2Ready) begin
            out_valid <= s2Valid;
            if (s2Valid) begin
                res_sign <= signC;
                res_exp  <= s2XExp;
                res_man  <= sumC;
            end
        end
    end

endmodule

// File: tb/tb_fma_align_add.sv
// ---------------------------------------------------------------------------
// tb_fma_align_add
//
// Directed bench for fma_align_add. The expected values are worked out by
// hand from the alignment arithmetic. For example, a 2.46 significand of 1.0
// is 48'h4000_0000_0000, which becomes bit 48 once two guard bits are added.
// The sticky-dependent expectations follow FMA_ALIGN_STICKY_EN, so the bench
// matches whichever build it is compiled with.
// ---------------------------------------------------------------------------
module tb_fma_align_add;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        ab_sign;
    logic        cd_sign;
    logic [9:0]  ab_exp;
    logic [9:0]  cd_exp;
    logic [47:0] ab_man;
    logic [47:0] cd_man;
    logic        op_sel;
    logic        out_valid;
    logic        out_ready;
    logic        res_sign;
    logic [9:0]  res_exp;
    logic [50:0] res_man;

`ifdef FMA_ALIGN_STICKY_EN
    localparam logic [50:0] STICKY = 51'd1;
`else
    localparam logic [50:0] STICKY = 51'd0;
`endif

    localparam logic [47:0] ONE   = 48'h4000_0000_0000;
    localparam logic [47:0] TWO   = 48'h8000_0000_0000;
    localparam logic [47:0] ALL1  = 48'hFFFF_FFFF_FFFF;
    localparam logic [50:0] BASE1 = 51'h1_0000_0000_0000;
    localparam logic [50:0] BASE2 = 51'h2_0000_0000_0000;

    int compared   = 0;
    int mismatched = 0;

    // {sign, exp, man} of each expected result, in acceptance order
    logic [61:0] exp_q[$];

    fma_align_add dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ab_sign   (ab_sign),
        .cd_sign   (cd_sign),
        .ab_exp    (ab_exp),
        .cd_exp    (cd_exp),
        .ab_man    (ab_man),
        .cd_man    (cd_man),
        .op_sel    (op_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res_sign  (res_sign),
        .res_exp   (res_exp),
        .res_man   (res_man)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic setPair(input logic as, input logic [9:0] ae, input logic [47:0] am,
                           input logic cs, input logic [9:0] ce, input logic [47:0] cm,
                           input logic op);
        ab_sign = as;
        ab_exp  = ae;
        ab_man  = am;
        cd_sign = cs;
        cd_exp  = ce;
        cd_man  = cm;
        op_sel  = op;
    endtask

    // Offer one pair with out_ready high, then check its latency and result.
    task automatic runPair(input string tag,
                           input logic as, input logic [9:0] ae, input logic [47:0] am,
                           input logic cs, input logic [9:0] ce, input logic [47:0] cm,
                           input logic op,
                           input logic eSign, input logic [9:0] eExp, input logic [50:0] eMan);
        int lat;
        setPair(as, ae, am, cs, ce, cm, op);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        #1;
        check({tag, " in_ready"}, 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 8) begin
            step();
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'd3);
        check({tag, " sign"}, 64'(res_sign), 64'(eSign));
        check({tag, " exp"}, 64'(res_exp), 64'(eExp));
        check({tag, " man"}, 64'(res_man), 64'(eMan));
        step();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int idx;
        int sawValid;
        logic [61:0] expEntry;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        setPair(1'b0, 10'd0, 48'd0, 1'b0, 10'd0, 48'd0, 1'b0);
        repeat (3) step();

        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset res_sign", 64'(res_sign), 64'd0);
        check("reset res_exp", 64'(res_exp), 64'd0);
        check("reset res_man", 64'(res_man), 64'd0);
        rst_n = 1'b1;
        step();
        check("post-reset in_ready", 64'(in_ready), 64'd1);

        runPair("add_equal", 1'b0, 10'd0, ONE, 1'b0, 10'd0, ONE, 1'b0, 1'b0, 10'd0, BASE2);
        runPair("sub_zero", 1'b1, 10'd0, ONE, 1'b0, 10'd0, ONE, 1'b1, 1'b0, 10'd0, 51'd0);
        runPair("tie_ab_sign", 1'b1, 10'd0, ONE, 1'b0, 10'd0, ONE, 1'b0, 1'b1, 10'd0, BASE2);
        runPair("add_shift2", 1'b0, 10'd5, ONE, 1'b0, 10'd3, ONE, 1'b0,
                1'b0, 10'd5, 51'h1_4000_0000_0000);
        runPair("far_small", 1'b0, 10'd0, ONE, 1'b0, 10'h3C4, 48'h1, 1'b0,
                1'b0, 10'd0, BASE1 + STICKY);
        runPair("swap_sub", 1'b0, 10'd3, ONE, 1'b1, 10'd5, ONE, 1'b1,
                1'b1, 10'd5, 51'h0_C000_0000_0000);
        runPair("eq_exp_cd_big", 1'b0, 10'h3FE, ONE, 1'b1, 10'h3FE, TWO, 1'b1,
                1'b1, 10'h3FE, BASE1);
        runPair("neg_exp", 1'b0, 10'h3FF, ONE, 1'b0, 10'd2, ONE, 1'b0,
                1'b0, 10'd2, 51'h1_2000_0000_0000);
        runPair("sticky_mid", 1'b0, 10'd0, ONE, 1'b0, 10'h3FD, 48'h5, 1'b0,
                1'b0, 10'd0, BASE1 + 51'd2 + STICKY);
        runPair("diff49", 1'b0, 10'd0, ONE, 1'b0, 10'h3CF, TWO, 1'b0,
                1'b0, 10'd0, BASE1 + 51'd1);
        runPair("diff50", 1'b0, 10'd0, ONE, 1'b0, 10'h3CE, ALL1, 1'b0,
                1'b0, 10'd0, BASE1 + STICKY);
        runPair("max_carry", 1'b0, 10'd0, ALL1, 1'b0, 10'd0, ALL1, 1'b0,
                1'b0, 10'd0, 51'h7_FFFF_FFFF_FFF8);
        runPair("exp_extreme", 1'b0, 10'h1FF, ONE, 1'b1, 10'h200, 48'h1, 1'b0,
                1'b0, 10'h1FF, BASE1 + STICKY);

        // ---- backpressure: 4 pairs offered while out_ready is low ----
        out_ready = 1'b0;
        exp_q.delete();
        idx = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            setPair(1'b0, 10'(idx + 1), ONE, 1'b0, 10'(idx + 1), ONE, 1'b0);
            in_valid = 1'b1;
            #1;
            if (in_ready) begin
                exp_q.push_back({1'b0, 10'(idx + 1), BASE2});
                idx++;
            end
            step();
            if (cyc >= 2) begin
                check("stall out_valid", 64'(out_valid), 64'd1);
                check("stall hold", 64'({res_sign, res_exp, res_man}), 64'({1'b0, 10'd1, BASE2}));
            end
        end
        check("stall accepted", 64'(idx), 64'd3);

        setPair(1'b0, 10'(idx + 1), ONE, 1'b0, 10'(idx + 1), ONE, 1'b0);
        out_ready = 1'b1;
        #1;
        check("release in_ready", 64'(in_ready), 64'd1);
        exp_q.push_back({1'b0, 10'(idx + 1), BASE2});
        for (int k = 0; k < 4; k++) begin
            check("drain out_valid", 64'(out_valid), 64'd1);
            if (exp_q.size() > 0) begin
                expEntry = exp_q.pop_front();
                check("drain order", 64'({res_sign, res_exp, res_man}), 64'(expEntry));
            end else begin
                check("drain queue empty", 64'(exp_q.size()), 64'd1);
            end
            step();
            in_valid = 1'b0;
        end
        check("drain done", 64'(out_valid), 64'd0);
        check("drain queue", 64'(exp_q.size()), 64'd0);

        // ---- reset with two pairs in flight ----
        out_ready = 1'b1;
        setPair(1'b0, 10'd7, ONE, 1'b0, 10'd7, ONE, 1'b0);
        in_valid = 1'b1;
        step();
        setPair(1'b0, 10'd8, ONE, 1'b0, 10'd8, ONE, 1'b0);
        step();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        step();
        rst_n = 1'b1;
        check("reset flush in_ready", 64'(in_ready), 64'd1);
        sawValid = 0;
        for (int k = 0; k < 6; k++) begin
            if (out_valid === 1'b1) sawValid++;
            step();
        end
        check("reset flush no output", 64'(sawValid), 64'd0);
        runPair("after_reset", 1'b0, 10'd5, ONE, 1'b0, 10'd3, ONE, 1'b0,
                1'b0, 10'd5, 51'h1_4000_0000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fma_align_add.md
FMA_ALIGN_ADD -- requirements
Module: fma_align_add

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst_n  input  1  synchronous active-low reset.
REQ-003 SHALL have port: in_valid  input  1  product pair presented.
REQ-004 SHALL have port: in_ready  output  1  block accepts pair this cycle.
REQ-005 SHALL have ports: ab_sign, cd_sign  input  1 each  signs of products a*b, c*d.
REQ-006 SHALL have ports: ab_exp, cd_exp  input  10 each  two's-complement unbiased product exponents.
REQ-007 SHALL have ports: ab_man, cd_man  input  48 each  unsigned product significands, format 2.46.
REQ-008 SHALL have port: op_sel  input  1  effective operation from the sign/op selector; 1 = magnitude subtract, 0 = magnitude add.
REQ-009 SHALL have ports: out_valid  output  1  and  out_ready  input  1  output handshake.
REQ-010 SHALL have ports: res_sign  output  1;  res_exp  output  10;  res_man  output  51  unnormalised magnitude, bit 50 = carry.

Function
REQ-011 SHALL transfer on any cycle where valid and ready are both high, on either side.
REQ-012 SHALL be a 3-stage pipeline; an unstalled pair appears on out_valid exactly 3 cycles after acceptance.
REQ-013 Stage k SHALL load when its upstream register is valid and it is empty or being drained this cycle; ready_3 = out_ready, ready_k = ~v_(k+1) | ready_(k+1), in_ready = ~v_1 | ready_1.
REQ-014 SHALL sustain one transfer per cycle with out_ready held high; in_ready SHALL drop only when all three stages hold data and out_ready is low.
REQ-015 Stage 1: signed compare of exponents; operand with larger exponent becomes X, the other Y; on equal exponents, larger significand becomes X, ab if the significands are also equal; diff = X.exp - Y.exp (unsigned, 11 bits).
REQ-016 Stage 2: extend each significand to 50 bits as {man, 2'b00}; right-shift Y by diff; diff >= 50 SHALL yield shifted Y = 0 (plus sticky per REQ-024).
REQ-017 Stage 3: op_sel = 0 gives res_man = X + Y (51 bits); op_sel = 1 gives res_man = X - Y, never negative by REQ-015.
REQ-018 res_sign SHALL be X.sign, except that an exact zero result SHALL give res_sign = 0.
REQ-019 res_exp SHALL equal X.exp.
REQ-020 While out_valid is high and out_ready is low, all outputs SHALL remain stable.
REQ-021 Results SHALL emerge in acceptance order; no drop or duplication under any stall pattern.

Reset
REQ-022 When rst_n is low at a clock edge, all stage valid bits SHALL clear; out_valid = 0, res_sign = 0, res_exp = 0, res_man = 0.
REQ-023 Reset mid-operation SHALL discard in-flight pairs; in_ready SHALL be 1 on the first cycle after rst_n returns high.

Configuration
REQ-024 With FMA_ALIGN_STICKY_EN defined, stage 2 SHALL OR all bits shifted out of Y into bit 0 of the shifted Y; without it, shifted-out bits SHALL be discarded and bit 0 SHALL come from the shift alone.

Verification
REQ-025 ab = cd = (+, exp 0, man 48'h4000_0000_0000), op_sel 0 -> res_man 51'h2_0000_0000_0000, res_exp 0, res_sign 0, out_valid 3 cycles after acceptance.
REQ-026 Same operands with ab_sign 1, op_sel 1 -> res_man 0, res_sign 0.
REQ-027 ab exp 5, cd exp 3, both man 48'h4000_0000_0000, op_sel 0 -> res_man 51'h1_4000_0000_0000, res_exp 5.
REQ-028 ab (exp 0, man 48'h4000_0000_0000), cd (exp -60, man 48'h1), op_sel 0 -> res_man 51'h1_0000_0000_0001 with macro, 51'h1_0000_0000_0000 without.
REQ-029 out_ready low 6 cycles while 4 pairs are offered back-to-back -> exactly 3 accepted, outputs stable; out_ready then high -> 4 results in order, one per cycle.
REQ-030 rst_n low for one cycle with 2 pairs in flight -> no out_valid from them; a new pair after reset returns a correct result at latency 3.
